// File: rtl/reg_pkg.sv
// reg_pkg: shared types and defaults for the integer register-file writer.
//   XLEN_DEF / AW_DEF / QDEPTH_DEF : default data width, address width, ALU queue depth
//   REG_X0                         : address of the hardwired-zero register
//   wb_req_t                       : {rd, data} result record used by execute, load and writeback
package reg_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int AW_DEF     = 5;
  localparam int QDEPTH_DEF = 2;

  localparam logic [AW_DEF-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [AW_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of wb_req_t records with a show-ahead head.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : enqueue din at the tail (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry (valid while !empty)
module wb_fifo
  import reg_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push, do_pop;

  // Explicit wrap keeps DEPTH=1 correct, where a 1-bit pointer would otherwise reach 1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: drives the register file's single write port from the ALU
// (valid/ready) and the load unit (never stalls), queueing displaced ALU results
// in order, and keeps a per-register busy scoreboard for hazard detection.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   alu_valid/ready/rd/data      : ALU result handshake
//   ld_valid/rd/data             : load result, always accepted
//   iss_valid, iss_rd            : destination of the instruction issuing this cycle
//   write, rd, rddata            : registered register-file write port
//   busy                         : bit i set while a write to xi is pending
// Optional macro REG_WB_BYPASS_EN adds same-cycle forwarding ports
//   fwd_rs1/fwd_rs2 -> fwd_rs1data/fwd_rs2data, fwd_rs1hit/fwd_rs2hit.
module reg_writeback
  import reg_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = AW_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              write,
  output logic [AW-1:0]     rd,
  output logic [XLEN-1:0]   rddata,
  output logic [2**AW-1:0]  busy
`ifdef REG_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]     fwd_rs1,
  input  logic [AW-1:0]     fwd_rs2,
  output logic [XLEN-1:0]   fwd_rs1data,
  output logic [XLEN-1:0]   fwd_rs2data,
  output logic              fwd_rs1hit,
  output logic              fwd_rs2hit
`endif
);

  wb_req_t            alu_req, q_head, sel_req;
  logic               q_full, q_empty, q_push, q_pop;
  logic               sel_valid, alu_fire;
  logic               write_q;
  logic [AW-1:0]      rd_q;
  logic [XLEN-1:0]    rddata_q;
  logic [2**AW-1:0]   busy_q, busy_d;

  assign alu_ready = !q_full;
  assign alu_fire  = alu_valid && alu_ready;
  assign alu_req   = '{rd: alu_rd, data: alu_data};

  // Priority: load, then queued ALU results, then ALU bypass. An accepted ALU
  // result that is not taken directly goes to the queue tail, so ALU order holds.
  always_comb begin
    sel_valid = 1'b0;
    sel_req   = alu_req;
    q_pop     = 1'b0;
    q_push    = 1'b0;
    if (ld_valid) begin
      sel_valid = 1'b1;
      sel_req   = '{rd: ld_rd, data: ld_data};
      q_push    = alu_fire;
    end else if (!q_empty) begin
      sel_valid = 1'b1;
      sel_req   = q_head;
      q_pop     = 1'b1;
      q_push    = alu_fire;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel_req   = alu_req;
    end
  end

  wb_fifo #(.DEPTH(QDEPTH)) u_alu_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .din   (alu_req),
    .pop   (q_pop),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  // Clear on selection, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (sel_valid) busy_d[sel_req.rd] = 1'b0;
    if (iss_valid && (iss_rd != REG_X0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      rd_q     <= '0;
      rddata_q <= '0;
      busy_q   <= '0;
    end else begin
      // x0 results are consumed but suppressed at the write enable.
      write_q <= sel_valid && (sel_req.rd != REG_X0);
      if (sel_valid) begin
        rd_q     <= sel_req.rd;
        rddata_q <= sel_req.data;
      end
      busy_q <= busy_d;
    end
  end

  assign write  = write_q;
  assign rd     = rd_q;
  assign rddata = rddata_q;
  assign busy   = busy_q;

`ifdef REG_WB_BYPASS_EN
  assign fwd_rs1hit  = write_q && (rd_q == fwd_rs1) && (fwd_rs1 != REG_X0);
  assign fwd_rs2hit  = write_q && (rd_q == fwd_rs2) && (fwd_rs2 != REG_X0);
  assign fwd_rs1data = fwd_rs1hit ? rddata_q : '0;
  assign fwd_rs2data = fwd_rs2hit ? rddata_q : '0;
`endif

`ifndef SYNTHESIS
  // Re-issuing a register is only legitimate in the cycle its pending result retires.
  iss_not_busy_a : assert property (@(posedge clk) disable iff (!rst_n)
    (iss_valid && (iss_rd != REG_X0) && !(sel_valid && (sel_req.rd == iss_rd)))
      |-> !busy_q[iss_rd]);
`endif

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writer side of the 32-entry integer register file. Drives the register file's single write port (write, rd, rddata) from two result sources:
  - the ALU/execute stage, with a valid/ready handshake;
  - the load unit, which cannot stall.
- Holds a 2-entry in-order queue for ALU results displaced by loads.
- Keeps a per-register busy scoreboard so issue logic can detect RAW/WAW hazards against in-flight writes.

Parameters:
- XLEN, 32, data width of results and register write data.
- AW, 5, register address width (2**AW registers; x0 hardwired zero).
- QDEPTH, 2, ALU pending-queue depth (power of two, >=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result present; always accepted, no ready.
- ld_rd  in  AW  load destination register.
- ld_data  in  XLEN  load result.
- iss_valid  in  1  an instruction with a destination is issuing this cycle.
- iss_rd  in  AW  its destination register.
- write  out  1  register file write enable.
- rd  out  AW  register file write address.
- rddata  out  XLEN  register file write data.
- busy  out  2**AW  scoreboard; bit i=1 means a write to xi is pending.

Behaviour:
- Reset (async, rst_n=0):
  - write=0, rd=0, rddata=0, busy=0, queue empty.
  - alu_ready is combinational and reads 1 while the queue is empty, including during reset.
  - An in-flight result at reset is discarded; there is no partial write.
- Write-port outputs are registered. A result selected in cycle N appears on write/rd/rddata in cycle N+1, for exactly one cycle.
- Selection each cycle, highest priority first:
  1. ld_valid=1: select the load.
  2. Else if the queue is non-empty: select the queue head and pop it.
  3. Else if alu_valid=1: select the ALU input directly (queue bypass).
  4. Else write=0 next cycle.
- Handshake:
  - alu_ready = (queue count < QDEPTH).
  - An ALU handshake (alu_valid & alu_ready) that is not selected directly is pushed to the queue tail.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - ALU results always write back in acceptance order.
  - Load vs ALU order is not preserved. Issue logic guarantees distinct rd via busy.
- Queue:
  - Full (count=QDEPTH): alu_ready=0; the ALU must hold its valid/data.
  - Pointers wrap modulo QDEPTH.
- x0 handling:
  - A selected result with rd=0 produces write=0 next cycle.
  - The rd/rddata output registers still update; the value is don't-care.
  - The result is still consumed: dequeued or accepted.
- Scoreboard:
  - Set: iss_valid=1 and iss_rd!=0 sets busy[iss_rd] at the next edge.
  - Clear: busy[rd_sel] clears at the edge where the result is selected. The bit is therefore already 0 in the same cycle write=1 is presented.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is always 0.
  - Issue asserting iss_valid on an already-busy rd is illegal. This is an upstream responsibility and is checked by assertion in simulation only.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- Defined: adds these ports:
  - fwd_rs1, fwd_rs2 (in, AW)
  - fwd_rs1data, fwd_rs2data (out, XLEN)
  - fwd_rs1hit, fwd_rs2hit (out, 1)
- Forwarding logic (combinational):
  - hit = write & (rd == fwd_rsX) & (fwd_rsX != 0).
  - data = rddata when hit, else 0.
  - Lets the read stage see a same-cycle write that the register file would only show one cycle later.
- Undefined: these ports and their logic are absent. The port list is otherwise identical.

Decomposition:
- Package reg_pkg:
  - XLEN/AW defaults.
  - REG_X0 constant.
  - struct wb_req_t {rd, data}, shared with execute and load units.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_req_t.
  - Ports: push, pop, full, empty, head.
  - Instantiated once for the ALU queue.

Test Plan:
- Reset mid-operation: queue holds 2 entries and busy=0x0000_0006; assert rst_n=0 -> write=0, busy=0, alu_ready=1 immediately, no write after release.
- ALU only: alu_valid with rd=5, data=0xDEADBEEF at cycle N -> cycle N+1: write=1, rd=5, rddata=0xDEADBEEF; alu_ready stays 1.
- Load/ALU collision:
  - Stimulus: ld rd=3 data=0x11 for 3 consecutive cycles; ALU results rd=7,8,9 offered in the same cycles.
  - Required: loads write first; alu_ready drops after the 2nd ALU accept; then x7, x8, x9 write back in order.
- Scoreboard: iss rd=10 -> busy[10]=1 next cycle; ALU result rd=10 selected -> busy[10]=0 in the cycle write=1. Same-cycle iss rd=12 and select rd=12 -> busy[12] stays 1.
- x0: ALU rd=0 data=0xFFFF_FFFF -> consumed, write=0, busy unchanged; iss rd=0 -> busy[0]=0.
- REG_WB_BYPASS_EN: write rd=4 data=0x1234 while fwd_rs1=4, fwd_rs2=0 -> fwd_rs1hit=1, fwd_rs1data=0x1234, fwd_rs2hit=0.
